// File: rtl/dma_channel_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | dma_channel_arbiter : round-robin owner arbitration for a single DMA engine |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module dma_channel_arbiter #(
  parameter int NCH     = 4,
  parameter int ADDR_W  = 32,
  parameter int LEN_W   = 16,
  parameter int TIMEOUT = 1024
) (
  input  logic                    hclk,
  input  logic                    hreset,
  input  logic                    hready_i,
  input  logic [NCH-1:0]          ch_req,
  input  logic [NCH*ADDR_W-1:0]   ch_addr,
  input  logic [NCH*LEN_W-1:0]    ch_len,
  input  logic                    done,
  output logic [NCH-1:0]          grant,
  output logic                    dma_start,
  output logic [ADDR_W-1:0]       dma_addr,
  output logic [LEN_W-1:0]        dma_len,
  output logic                    dma_abort,
  output logic [NCH-1:0]          ch_ack,
  output logic [NCH-1:0]          ch_err,
  output logic                    busy
);

  localparam int               IDX_W      = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [15:0]      c_wd_limit = 16'(TIMEOUT - 1);
  localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(NCH - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_START  = 2'd1,
    S_BUSY   = 2'd2,
    S_FINISH = 2'd3
  } state_t;

  state_t           r_state;
  logic [IDX_W-1:0] r_rr_ptr;
  logic [IDX_W-1:0] r_idx;
  logic [15:0]      r_wd;

  logic             w_found;
  logic [IDX_W-1:0] w_sel_idx;
  logic [NCH-1:0]   w_sel_onehot;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [LEN_W-1:0] w_sel_len;
  logic [IDX_W-1:0] w_next_ptr;
  int               w_pos;

  // Scan channels starting at the round-robin pointer, wrapping once.
  always_comb begin
    w_found      = 1'b0;
    w_sel_idx    = '0;
    w_sel_onehot = '0;
    w_sel_addr   = '0;
    w_sel_len    = '0;
    w_pos        = 0;
    for (int k = 0; k < NCH; k++) begin
      w_pos = int'(r_rr_ptr) + k;
      if (w_pos >= NCH) w_pos = w_pos - NCH;
      if (!w_found && ch_req[w_pos]) begin
        w_found             = 1'b1;
        w_sel_idx           = IDX_W'(w_pos);
        w_sel_onehot[w_pos] = 1'b1;
        w_sel_addr          = ch_addr[w_pos*ADDR_W +: ADDR_W];
        w_sel_len           = ch_len[w_pos*LEN_W +: LEN_W];
      end
    end
  end

  assign w_next_ptr = (r_idx == c_last_idx) ? '0 : r_idx + 1'b1;

  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      r_state   <= S_IDLE;
      r_rr_ptr  <= '0;
      r_idx     <= '0;
      r_wd      <= '0;
      grant     <= '0;
      dma_start <= 1'b0;
      dma_addr  <= '0;
      dma_len   <= '0;
      dma_abort <= 1'b0;
      ch_ack    <= '0;
      ch_err    <= '0;
    end else begin
      dma_abort <= 1'b0;
      ch_ack    <= '0;
      ch_err    <= '0;
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_idx     <= w_sel_idx;
            grant     <= w_sel_onehot;
            dma_addr  <= w_sel_addr;
            dma_len   <= w_sel_len;
            dma_start <= (w_sel_len != '0);
            r_state   <= S_START;
          end
        end
        S_START: begin
          if (dma_len == '0) begin
            dma_start <= 1'b0;
            r_state   <= S_FINISH;
          end else if (hready_i) begin
            dma_start <= 1'b0;
            r_wd      <= '0;
            r_state   <= S_BUSY;
          end
        end
        S_BUSY: begin
          // Completion takes priority over a coincident watchdog expiry.
          if (done) begin
            r_state <= S_FINISH;
          end else if (r_wd == c_wd_limit) begin
            dma_abort <= 1'b1;
            ch_err    <= grant;
            grant     <= '0;
            r_rr_ptr  <= w_next_ptr;
            r_state   <= S_IDLE;
          end else begin
            r_wd <= r_wd + 16'd1;
          end
        end
        S_FINISH: begin
          ch_ack   <= grant;
          grant    <= '0;
          r_rr_ptr <= w_next_ptr;
          r_state  <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_dma_channel_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_dma_channel_arbiter : directed + randomized transactions vs a txn model  |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_dma_channel_arbiter;

  localparam int NCH     = 4;
  localparam int ADDR_W  = 32;
  localparam int LEN_W   = 16;
  localparam int TIMEOUT = 16;

  logic                  hclk = 1'b0;
  logic                  hreset;
  logic                  hready_i;
  logic [NCH-1:0]        ch_req;
  logic [NCH*ADDR_W-1:0] ch_addr;
  logic [NCH*LEN_W-1:0]  ch_len;
  logic                  done;
  logic [NCH-1:0]        grant;
  logic                  dma_start;
  logic [ADDR_W-1:0]     dma_addr;
  logic [LEN_W-1:0]      dma_len;
  logic                  dma_abort;
  logic [NCH-1:0]        ch_ack;
  logic [NCH-1:0]        ch_err;
  logic                  busy;

  int n_pass   = 0;
  int n_fail   = 0;
  int n_total  = 0;
  int rr_model = 0;

  dma_channel_arbiter #(
    .NCH     (NCH),
    .ADDR_W  (ADDR_W),
    .LEN_W   (LEN_W),
    .TIMEOUT (TIMEOUT)
  ) u_dut (
    .hclk      (hclk),
    .hreset    (hreset),
    .hready_i  (hready_i),
    .ch_req    (ch_req),
    .ch_addr   (ch_addr),
    .ch_len    (ch_len),
    .done      (done),
    .grant     (grant),
    .dma_start (dma_start),
    .dma_addr  (dma_addr),
    .dma_len   (dma_len),
    .dma_abort (dma_abort),
    .ch_ack    (ch_ack),
    .ch_err    (ch_err),
    .busy      (busy)
  );

  always #5 hclk = ~hclk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total = n_total + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else begin
      n_fail = n_fail + 1;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge hclk);
    #1;
  endtask

  // Owner chosen by the arbitration rule: first requester at or after the pointer.
  function automatic int pick(input logic [NCH-1:0] req, input int rr);
    for (int k = 0; k < NCH; k++)
      if (req[(rr + k) % NCH]) return (rr + k) % NCH;
    return 0;
  endfunction

  task automatic scramble();
    for (int i = 0; i < NCH; i++) begin
      ch_addr[i*ADDR_W +: ADDR_W] = ADDR_W'($urandom);
      ch_len[i*LEN_W +: LEN_W]    = LEN_W'($urandom_range(1, 65535));
    end
  endtask

  // mode: 0 random nonzero length, 1 zero length, 2 fixed addr/len.
  // dly < TIMEOUT: done in BUSY cycle dly+1; otherwise the watchdog fires.
  task automatic run_txn(input logic [NCH-1:0] req, input int stall, input int dly,
                         input int mode, input logic [ADDR_W-1:0] fa, input logic [LEN_W-1:0] fl);
    int                ch;
    logic [NCH-1:0]    oh;
    logic [ADDR_W-1:0] ea;
    logic [LEN_W-1:0]  el;
    ch = pick(req, rr_model);
    oh = NCH'(1) << ch;
    scramble();
    if (mode == 1) ch_len[ch*LEN_W +: LEN_W] = '0;
    if (mode == 2) begin
      ch_addr[ch*ADDR_W +: ADDR_W] = fa;
      ch_len[ch*LEN_W +: LEN_W]    = fl;
    end
    ea       = ch_addr[ch*ADDR_W +: ADDR_W];
    el       = ch_len[ch*LEN_W +: LEN_W];
    ch_req   = req;
    hready_i = (stall == 0);
    done     = 1'($urandom);
    tick();
    chk("grant", grant, oh);
    chk("busy_granted", busy, 1);
    chk("dma_addr", dma_addr, ea);
    chk("dma_len", dma_len, el);
    chk("dma_start_first", dma_start, (mode != 1));
    chk("pulses_clear", {dma_abort, ch_ack, ch_err}, 0);
    // Late changes on the request side must not disturb the latched transfer.
    scramble();
    ch_req = NCH'($urandom);
    if (mode == 1) begin
      done = 1'($urandom);
      tick();
      chk("zl_no_start", dma_start, 0);
      chk("zl_busy", busy, 1);
      chk("zl_no_ack_yet", ch_ack, 0);
      done = 1'($urandom);
      tick();
      chk("zl_ack", ch_ack, oh);
      chk("zl_grant_clr", grant, 0);
      chk("zl_idle", busy, 0);
      chk("zl_no_err", {dma_abort, ch_err}, 0);
    end else begin
      for (int s = 0; s < stall; s++) begin
        done = 1'($urandom);
        tick();
        chk("stall_start", dma_start, 1);
        chk("stall_grant", grant, oh);
        chk("stall_addr", dma_addr, ea);
        chk("stall_len", dma_len, el);
      end
      hready_i = 1'b1;
      done     = 1'b0;
      tick();
      chk("busy_no_start", dma_start, 0);
      chk("busy_flag", busy, 1);
      hready_i = 1'($urandom);
      if (dly < TIMEOUT) begin
        for (int b = 0; b < dly; b++) begin
          tick();
          chk("busy_wait", {busy, dma_abort, ch_ack}, {1'b1, 1'b0, 4'b0});
        end
        done = 1'b1;
        tick();
        chk("finish_busy", busy, 1);
        chk("finish_no_ack_yet", ch_ack, 0);
        done = 1'($urandom);
        tick();
        chk("ack", ch_ack, oh);
        chk("ack_no_err", {dma_abort, ch_err}, 0);
        chk("ack_grant_clr", grant, 0);
        chk("ack_idle", busy, 0);
      end else begin
        for (int b = 1; b < TIMEOUT; b++) begin
          tick();
          chk("to_wait", {busy, dma_abort, ch_err}, {1'b1, 1'b0, 4'b0});
        end
        tick();
        chk("to_abort", dma_abort, 1);
        chk("to_err", ch_err, oh);
        chk("to_no_ack", ch_ack, 0);
        chk("to_grant_clr", grant, 0);
        chk("to_idle", busy, 0);
      end
    end
    done     = 1'b0;
    rr_model = (ch + 1) % NCH;
  endtask

  initial begin
    logic [NCH-1:0] rq;
    hreset   = 1'b1;
    hready_i = 1'b0;
    ch_req   = '1;
    done     = 1'b1;
    ch_addr  = '1;
    ch_len   = '1;
    tick();
    tick();
    chk("rst_grant", grant, 0);
    chk("rst_start", dma_start, 0);
    chk("rst_busy", busy, 0);
    chk("rst_addr", dma_addr, 0);
    chk("rst_len", dma_len, 0);
    chk("rst_pulses", {dma_abort, ch_ack, ch_err}, 0);

    ch_req = '0;
    done   = 1'b0;
    hreset = 1'b0;
    tick();
    tick();
    chk("idle_no_req", {busy, grant}, 0);

    for (int i = 0; i < 5; i++) run_txn(4'b1111, 0, 2, 0, '0, '0);
    run_txn(4'b0001, 0, 4, 2, 32'h0000_1000, 16'd8);
    run_txn(4'b0010, 3, 2, 0, '0, '0);
    run_txn(4'b1111, 0, 99, 0, '0, '0);
    run_txn(4'b1111, 1, 1, 0, '0, '0);
    run_txn(4'b1011, 0, TIMEOUT - 1, 0, '0, '0);
    run_txn(4'b0100, 0, 0, 1, '0, '0);
    run_txn(4'b0001, 0, 0, 0, '0, '0);

    // Abandon a transfer on channel 1 while BUSY.
    ch_req   = 4'b0010;
    hready_i = 1'b1;
    tick();
    tick();
    tick();
    #3;
    hreset = 1'b1;
    #1;
    chk("mid_rst_outputs", {grant, dma_start, dma_abort, ch_ack, ch_err, busy}, 0);
    chk("mid_rst_addr_len", {dma_addr, dma_len}, 0);
    ch_req = '0;
    tick();
    hreset = 1'b0;
    tick();
    tick();
    chk("post_rst_quiet", {grant, dma_abort, ch_ack, ch_err, busy}, 0);
    rr_model = 0;
    run_txn(4'b0101, 0, 1, 0, '0, '0);
    run_txn(4'b0100, 0, 1, 0, '0, '0);

    for (int i = 0; i < 40; i++) begin
      do rq = NCH'($urandom); while (rq == '0);
      run_txn(rq, $urandom_range(0, 3), $urandom_range(0, 20),
              ($urandom_range(0, 7) == 0) ? 1 : 0, '0, '0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dma_channel_arbiter.md
DMA_CHANNEL_ARBITER -- requirements
Module: dma_channel_arbiter

Interface
REQ-001 SHALL have parameter NCH, default 4: number of requesting channels.
REQ-002 SHALL have parameter ADDR_W, default 32: transfer address width.
REQ-003 SHALL have parameter LEN_W, default 16: transfer length width.
REQ-004 SHALL have parameter TIMEOUT, default 1024: maximum BUSY cycles before abort.
REQ-005 SHALL have one clock and an asynchronous, active-high reset.
REQ-006 hclk  in  1  sole clock; all state updates on rising edge.
REQ-007 hreset  in  1  reset; asynchronous assertion, active high.
REQ-008 hready_i  in  1  bus ready; DMA engine may accept a start.
REQ-009 ch_req  in  NCH  per-channel transfer request, level.
REQ-010 ch_addr  in  NCH*ADDR_W  per-channel start address; channel i occupies bits [i*ADDR_W +: ADDR_W].
REQ-011 ch_len  in  NCH*LEN_W  per-channel length; channel i occupies bits [i*LEN_W +: LEN_W].
REQ-012 done  in  1  DMA engine completion pulse.
REQ-013 grant  out  NCH  one-hot owner of the DMA engine; all-zero when idle.
REQ-014 dma_start  out  1  start request to the DMA engine.
REQ-015 dma_addr  out  ADDR_W  latched address of the granted channel.
REQ-016 dma_len  out  LEN_W  latched length of the granted channel.
REQ-017 dma_abort  out  1  one-cycle abort pulse on timeout.
REQ-018 ch_ack  out  NCH  one-cycle completion pulse to the granted channel.
REQ-019 ch_err  out  NCH  one-cycle timeout-error pulse to the granted channel.
REQ-020 busy  out  1  high in every state except IDLE.

Function
REQ-021 SHALL implement states IDLE, START, BUSY and FINISH.
REQ-022 IDLE: if any ch_req bit is set, SHALL select the first requesting channel at or after rr_ptr (modulo NCH), latch its addr/len into dma_addr/dma_len, set grant one-hot, and go to START next cycle.
REQ-023 IDLE with ch_req == 0 SHALL stay in IDLE with grant = 0.
REQ-024 START: dma_start = 1; on a cycle with hready_i = 1, SHALL go to BUSY; otherwise SHALL stay in START holding dma_start, grant, dma_addr and dma_len stable.
REQ-025 START with latched length 0 SHALL NOT assert dma_start and SHALL go directly to FINISH.
REQ-026 BUSY: dma_start = 0; a 16-bit watchdog SHALL clear on BUSY entry and increment each BUSY cycle.
REQ-027 BUSY with done = 1 SHALL go to FINISH.
REQ-028 BUSY with watchdog == TIMEOUT-1 and done = 0 SHALL pulse dma_abort and ch_err[grant] for one cycle, then go to IDLE.
REQ-029 done and timeout in the same cycle SHALL be treated as done: no abort, no err.
REQ-030 FINISH (one cycle) SHALL pulse ch_ack[grant] and go to IDLE.
REQ-031 On leaving FINISH or on a timeout, rr_ptr SHALL become (granted index + 1) mod NCH.
REQ-032 grant SHALL clear in the cycle the FSM returns to IDLE; the earliest next grant is the following cycle.
REQ-033 Deasserting ch_req after grant SHALL NOT cancel the transfer; the transfer completes normally.
REQ-034 done outside BUSY SHALL be ignored.
REQ-035 ch_addr/ch_len changes after latching SHALL NOT affect dma_addr/dma_len.
REQ-036 All outputs SHALL be driven from registers or from the state register only; no input-to-output combinational path.

Reset
REQ-037 While hreset = 1: state = IDLE, rr_ptr = 0, watchdog = 0, and grant, dma_start, dma_abort, ch_ack, ch_err, busy, dma_addr and dma_len all 0.
REQ-038 Reset asserted mid-transfer SHALL abandon the transfer silently: no ack, no err, no abort pulse.

Verification
REQ-039 Single request: ch_req=0001, addr=0x1000, len=8, hready_i=1, done 5 cycles after start -> grant=0001, dma_start for 1 cycle, ch_ack[0] pulse, busy drops.
REQ-040 Round-robin: ch_req=1111 held over 4 completed transfers -> grant order 0,1,2,3; a 5th transfer grants channel 0 again.
REQ-041 Stall: hready_i=0 for 3 cycles in START -> dma_start held 4 cycles with addr/len stable; BUSY is entered on the 4th cycle.
REQ-042 Timeout: TIMEOUT=16, done never asserted -> dma_abort and ch_err pulse 16 BUSY cycles after entry, no ch_ack, and the next grant goes to the following channel.
REQ-043 Zero length: ch_len[2]=0, only ch_req[2] set -> no dma_start and ch_ack[2] pulses 2 cycles after grant.
REQ-044 Reset mid-BUSY: hreset pulsed -> all outputs 0 immediately, and a new ch_req=0100 is granted channel 2 after release with rr_ptr starting from 0.
